// File: rtl/combat_resolver_pkg.sv
// combat_resolver_pkg: action encodings, round/winner encodings and shared helpers for the fight blocks.
package combat_resolver_pkg;
    localparam logic [5:0] ACT_WALKING   = 6'b000001;
    localparam logic [5:0] ACT_CROUCHING = 6'b000010;
    localparam logic [5:0] ACT_SHIELDING = 6'b000100;
    localparam logic [5:0] ACT_JUMPING   = 6'b001000;
    localparam logic [5:0] ACT_PUNCHING  = 6'b010000;
    localparam logic [5:0] ACT_STANDING  = 6'b100000;
    localparam int FACING_BIT = 6;
    localparam logic [3:0] HEALTH_MAX = 4'd15;

    typedef enum logic [1:0] {FIGHT = 2'b00, KO = 2'b01, DONE = 2'b10} round_e;
    typedef enum logic [1:0] {WIN_NONE = 2'b00, WIN_P0 = 2'b01, WIN_P1 = 2'b10, WIN_DRAW = 2'b11} winner_e;

    function automatic logic is_act(logic [5:0] action, logic [5:0] act);
        return (action & act) != 6'd0;
    endfunction

    // Attacker faces the defender (equal x counts for either facing) and is within range.
    function automatic logic in_reach(logic left, logic [9:0] ax, logic [9:0] dx, logic [9:0] range);
        return (left ? dx <= ax : dx >= ax) && ((ax > dx ? ax - dx : dx - ax) <= range);
    endfunction

    function automatic logic [3:0] sat_sub(logic [3:0] h, logic [3:0] d);
        return h > d ? h - d : 4'd0;
    endfunction
endpackage

// File: rtl/combat_resolver_if.sv
// combat_resolver_if: player state into the resolver, health/pulses/round status back out.
interface combat_resolver_if;
    logic [6:0] p0_action, p1_action;
    logic       p0_attack_request, p1_attack_request;
    logic       p0_jump_active, p1_jump_active;
    logic [3:0] p0_shield, p1_shield;
    logic [9:0] p0_x, p1_x;
    logic       rematch;
    logic [3:0] p0_health, p1_health;
    logic       p0_hit, p1_hit;
    logic       p0_blocked, p1_blocked;
    logic [1:0] round_state;
    logic [1:0] winner;

    modport master (
        output p0_action, p1_action, p0_attack_request, p1_attack_request,
               p0_jump_active, p1_jump_active, p0_shield, p1_shield, p0_x, p1_x, rematch,
        input  p0_health, p1_health, p0_hit, p1_hit, p0_blocked, p1_blocked, round_state, winner
    );

    modport slave (
        input  p0_action, p1_action, p0_attack_request, p1_attack_request,
               p0_jump_active, p1_jump_active, p0_shield, p1_shield, p0_x, p1_x, rematch,
        output p0_health, p1_health, p0_hit, p1_hit, p0_blocked, p1_blocked, round_state, winner
    );
endinterface

// File: rtl/combat_resolver_hurt_timer.sv
// hurt_timer: loadable down-counter that idles at zero; busy while nonzero.
module hurt_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         busy
);
    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge reset)
        if (!reset) cnt <= '0;
        else if (clear) cnt <= '0;
        else if (load) cnt <= load_val;
        else if (cnt != '0) cnt <= cnt - 1'b1;

    assign busy = cnt != '0;
endmodule

// File: rtl/combat_resolver.sv
// combat_resolver: punch qualification, health ownership and FIGHT/KO/DONE round sequencing for two players.
module combat_resolver
    import combat_resolver_pkg::*;
#(
    parameter logic [9:0]  HIT_RANGE      = 10'd64,
    parameter logic [3:0]  PUNCH_DAMAGE   = 4'd2,
    parameter logic [3:0]  CROUCH_DAMAGE  = 4'd1,
    parameter int unsigned INVULN_CYCLES  = 25_000_000,
    parameter int unsigned KO_HOLD_CYCLES = 200_000_000
) (
    input logic clk,
    input logic reset,
    combat_resolver_if.slave bus
);
    localparam int IW = $clog2(INVULN_CYCLES + 1);
    localparam int KW = $clog2(KO_HOLD_CYCLES + 1);

    round_e     state, state_n;
    winner_e    winner, winner_n;
    logic [3:0] h0, h1, h0_n, h1_n, dmg0, dmg1;
    logic       hit0, hit1, blk0, blk1, hit0_n, hit1_n;
    logic       rem_q, rem_qq, clr, ko_load, ko_busy, inv0_busy, inv1_busy;
    logic       fight, atk0, atk1, shield0, shield1;

    // atk0 is p0's punch qualifying against p1; atk1 the reverse.
    assign fight = state == FIGHT;
    assign atk0 = fight && bus.p0_attack_request && !inv1_busy && bus.p0_jump_active == bus.p1_jump_active
                  && in_reach(bus.p0_action[FACING_BIT], bus.p0_x, bus.p1_x, HIT_RANGE);
    assign atk1 = fight && bus.p1_attack_request && !inv0_busy && bus.p1_jump_active == bus.p0_jump_active
                  && in_reach(bus.p1_action[FACING_BIT], bus.p1_x, bus.p0_x, HIT_RANGE);
    assign shield0 = is_act(bus.p0_action[5:0], ACT_SHIELDING) && bus.p0_shield != 4'd0;
    assign shield1 = is_act(bus.p1_action[5:0], ACT_SHIELDING) && bus.p1_shield != 4'd0;
    assign hit0_n = atk1 && !shield0;
    assign hit1_n = atk0 && !shield1;
    assign dmg0 = !hit0_n ? 4'd0 : is_act(bus.p0_action[5:0], ACT_CROUCHING) ? CROUCH_DAMAGE : PUNCH_DAMAGE;
    assign dmg1 = !hit1_n ? 4'd0 : is_act(bus.p1_action[5:0], ACT_CROUCHING) ? CROUCH_DAMAGE : PUNCH_DAMAGE;

    always_comb begin
        state_n = state;
        winner_n = winner;
        h0_n = h0;
        h1_n = h1;
        ko_load = 1'b0;
        clr = 1'b0;
        case (state)
            FIGHT: begin
                h0_n = sat_sub(h0, dmg0);
                h1_n = sat_sub(h1, dmg1);
                if (h0_n == 4'd0 || h1_n == 4'd0) begin
                    state_n = KO;
                    ko_load = 1'b1;
                    winner_n = h0_n == 4'd0 && h1_n == 4'd0 ? WIN_DRAW : h1_n == 4'd0 ? WIN_P0 : WIN_P1;
                end
            end
            KO: state_n = ko_busy ? KO : DONE;
            DONE: if (rem_q && !rem_qq) begin
                state_n = FIGHT;
                h0_n = HEALTH_MAX;
                h1_n = HEALTH_MAX;
                winner_n = WIN_NONE;
                clr = 1'b1;
            end
            default: state_n = FIGHT;
        endcase
    end

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state <= FIGHT;
            winner <= WIN_NONE;
            h0 <= HEALTH_MAX;
            h1 <= HEALTH_MAX;
            hit0 <= 1'b0;
            hit1 <= 1'b0;
            blk0 <= 1'b0;
            blk1 <= 1'b0;
            rem_q <= 1'b0;
            rem_qq <= 1'b0;
        end else begin
            state <= state_n;
            winner <= winner_n;
            h0 <= h0_n;
            h1 <= h1_n;
            hit0 <= hit0_n;
            hit1 <= hit1_n;
            blk0 <= atk1 && shield0;
            blk1 <= atk0 && shield1;
            rem_q <= bus.rematch;
            rem_qq <= rem_q;
        end

    hurt_timer #(.W(IW)) u_inv0 (.clk, .reset, .clear(clr), .load(hit0_n),
                                 .load_val(IW'(INVULN_CYCLES - 1)), .busy(inv0_busy));
    hurt_timer #(.W(IW)) u_inv1 (.clk, .reset, .clear(clr), .load(hit1_n),
                                 .load_val(IW'(INVULN_CYCLES - 1)), .busy(inv1_busy));
    hurt_timer #(.W(KW)) u_ko   (.clk, .reset, .clear(1'b0), .load(ko_load),
                                 .load_val(KW'(KO_HOLD_CYCLES - 1)), .busy(ko_busy));

    assign bus.p0_health = h0;
    assign bus.p1_health = h1;
    assign bus.p0_hit = hit0;
    assign bus.p1_hit = hit1;
    assign bus.p0_blocked = blk0;
    assign bus.p1_blocked = blk1;
    assign bus.round_state = state;
    assign bus.winner = winner;
endmodule

// File: tb/tb_combat_resolver.sv
// tb_combat_resolver: directed and random punches against an edge-counting reference of the fight rules.
module tb_combat_resolver;
    localparam int INV = 16;
    localparam int KOH = 24;
    localparam int RANGE = 64;
    localparam logic [6:0] CROUCH = 7'h02, SHIELD = 7'h04, JUMP = 7'h08, STAND = 7'h20, LEFT = 7'h40;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int vectors = 0, miscompares = 0;
    int mh0, mh1, mst, mwin, e, last0, last1, ko_edge, rise_edge;
    bit prev_rem, mhit0, mhit1, mblk0, mblk1;

    combat_resolver_if bus();
    combat_resolver #(.INVULN_CYCLES(INV), .KO_HOLD_CYCLES(KOH)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h at edge %0d", tag, obs, exp, e);
        end
    endtask

    task automatic check_all();
        chk("p0_health", 8'(bus.p0_health), 8'(mh0));
        chk("p1_health", 8'(bus.p1_health), 8'(mh1));
        chk("p0_hit", 8'(bus.p0_hit), 8'(mhit0));
        chk("p1_hit", 8'(bus.p1_hit), 8'(mhit1));
        chk("p0_blocked", 8'(bus.p0_blocked), 8'(mblk0));
        chk("p1_blocked", 8'(bus.p1_blocked), 8'(mblk1));
        chk("round_state", 8'(bus.round_state), 8'(mst));
        chk("winner", 8'(bus.winner), 8'(mwin));
    endtask

    task automatic model_reset();
        mh0 = 15; mh1 = 15; mst = 0; mwin = 0;
        last0 = -1000; last1 = -1000; rise_edge = -1000; prev_rem = 0;
        mhit0 = 0; mhit1 = 0; mblk0 = 0; mblk1 = 0;
    endtask

    // since = edges elapsed since the defender was last hit
    function automatic bit lands(bit left, int ax, int dx, bit aj, bit dj, int since);
        return (left ? dx <= ax : dx >= ax) && (ax > dx ? ax - dx : dx - ax) <= RANGE && aj == dj && since >= INV;
    endfunction

    task automatic step();
        bit q01, q10;
        int d0, d1;
        q01 = mst == 0 && bus.p0_attack_request && lands(bus.p0_action[6], int'(bus.p0_x), int'(bus.p1_x),
              bus.p0_jump_active, bus.p1_jump_active, e - last1);
        q10 = mst == 0 && bus.p1_attack_request && lands(bus.p1_action[6], int'(bus.p1_x), int'(bus.p0_x),
              bus.p1_jump_active, bus.p0_jump_active, e - last0);
        mblk1 = q01 && bus.p1_action[2] && bus.p1_shield != 4'd0;
        mblk0 = q10 && bus.p0_action[2] && bus.p0_shield != 4'd0;
        mhit1 = q01 && !mblk1;
        mhit0 = q10 && !mblk0;
        d1 = !mhit1 ? 0 : bus.p1_action[1] ? 1 : 2;
        d0 = !mhit0 ? 0 : bus.p0_action[1] ? 1 : 2;
        if (mst == 0) begin
            mh0 = mh0 > d0 ? mh0 - d0 : 0;
            mh1 = mh1 > d1 ? mh1 - d1 : 0;
            if (mh0 == 0 || mh1 == 0) begin
                mst = 1;
                ko_edge = e;
                mwin = (mh0 == 0 && mh1 == 0) ? 3 : (mh1 == 0) ? 1 : 2;
            end
        end else if (mst == 1) begin
            if (e - ko_edge >= KOH) mst = 2;
        end else if (rise_edge == e - 1) begin
            mst = 0; mh0 = 15; mh1 = 15; mwin = 0; last0 = -1000; last1 = -1000;
        end
        if (mhit0) last0 = e;
        if (mhit1) last1 = e;
        if (bus.rematch && !prev_rem) rise_edge = e;
        prev_rem = bus.rematch;
        @(posedge clk);
        #1;
        e++;
        check_all();
        bus.p0_attack_request = 1'b0;
        bus.p1_attack_request = 1'b0;
    endtask

    task automatic idle(int n);
        repeat (n) step();
    endtask

    task automatic punch(bit a0, bit a1);
        bus.p0_attack_request = a0;
        bus.p1_attack_request = a1;
        step();
    endtask

    task automatic home();
        bus.p0_action = STAND; bus.p1_action = STAND;
        bus.p0_x = 10'd100; bus.p1_x = 10'd150;
        bus.p0_jump_active = 1'b0; bus.p1_jump_active = 1'b0;
        bus.p0_shield = 4'd0; bus.p1_shield = 4'd0;
    endtask

    function automatic logic [6:0] rand_action();
        logic [5:0] one;
        one = 6'b1 << $urandom_range(0, 5);
        return {1'($urandom_range(0, 1)), one};
    endfunction

    initial begin
        home();
        bus.p0_attack_request = 1'b0; bus.p1_attack_request = 1'b0; bus.rematch = 1'b0;
        e = 0;
        model_reset();
        #1 reset = 1'b0;
        #10 check_all();
        @(posedge clk);
        #1 reset = 1'b1;
        step();
        punch(1, 0);
        step();
        idle(8);
        punch(1, 0);
        idle(4);
        punch(1, 0);
        idle(1);
        punch(1, 0);
        idle(20);
        bus.p1_action = SHIELD; bus.p1_shield = 4'd5;
        punch(1, 0);
        bus.p1_shield = 4'd0;
        punch(1, 0);
        bus.p1_action = STAND;
        idle(20);
        bus.p0_action = STAND | LEFT;
        punch(1, 0);
        bus.p0_action = STAND; bus.p1_x = 10'd200;
        punch(1, 0);
        bus.p1_x = 10'd165;
        punch(1, 0);
        bus.p1_x = 10'd150; bus.p1_jump_active = 1'b1; bus.p1_action = JUMP;
        punch(1, 0);
        bus.p1_jump_active = 1'b0; bus.p1_action = STAND; bus.p1_x = 10'd164;
        punch(1, 0);
        bus.p1_x = 10'd150;
        idle(20);
        bus.p1_action = CROUCH;
        punch(1, 0);
        bus.p1_action = STAND;
        idle(20);
        bus.p1_x = 10'd100; bus.p0_action = STAND | LEFT;
        punch(1, 0);
        home();
        idle(20);
        while (mh1 > 2) begin
            punch(1, 0);
            idle(INV);
        end
        bus.p1_action = STAND | LEFT;
        while (mh0 > 2) begin
            bus.p0_action = mh0[0] ? CROUCH : STAND;
            punch(0, 1);
            idle(INV);
        end
        bus.p0_action = STAND;
        punch(1, 1);
        idle(KOH);
        idle(3);
        bus.rematch = 1'b1;
        step();
        step();
        bus.rematch = 1'b0;
        step();
        for (int i = 0; i < 800; i++) begin
            bus.p0_action = rand_action();
            bus.p1_action = rand_action();
            bus.p0_x = 10'($urandom_range(200, 330));
            bus.p1_x = ($urandom_range(0, 15) == 0) ? bus.p0_x : 10'($urandom_range(200, 330));
            bus.p0_jump_active = $urandom_range(0, 4) == 0;
            bus.p1_jump_active = $urandom_range(0, 4) == 0;
            bus.p0_shield = 4'($urandom_range(0, 2));
            bus.p1_shield = 4'($urandom_range(0, 2));
            bus.p0_attack_request = $urandom_range(0, 2) == 0;
            bus.p1_attack_request = $urandom_range(0, 2) == 0;
            if ($urandom_range(0, 9) == 0) bus.rematch = !bus.rematch;
            step();
        end
        home();
        bus.rematch = 1'b0;
        for (int i = 0; i < 3000 && mst != 1; i++) begin
            bus.rematch = (mst == 2) ? !bus.rematch : 1'b0;
            punch(1, 0);
        end
        chk("reached_ko", 8'(bus.round_state), 8'd1);
        bus.rematch = 1'b0;
        idle(3);
        #3 reset = 1'b0;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1 reset = 1'b1;
        punch(1, 0);
        step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
